// File: rtl/katana_tracker.sv
// katana_tracker: finds the centroid of red-marker pixels over one camera frame
// and presents it as katana_x/katana_y, held stable until the next frame's update.
module katana_tracker #(
    parameter int         H_ACTIVE   = 1024,
    parameter int         V_ACTIVE   = 768,
    parameter logic [3:0] R_MIN      = 4'd10,
    parameter logic [3:0] GB_MAX     = 4'd5,
    parameter int         MIN_PIXELS = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        pixel_valid_in,
    input  logic [11:0] pixel_in,
    output logic [10:0] katana_x,
    output logic [9:0]  katana_y,
    output logic        found_out,
    output logic        new_pos_out,
    output logic        busy_out
);

    localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM   = 10'(V_ACTIVE);
    localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);
    localparam logic [10:0] X_HOME  = 11'(H_ACTIVE / 2);
    localparam logic [9:0]  Y_HOME  = 10'(V_ACTIVE / 2);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, UPDATE} state_t;

    state_t      state, next_state;

    logic        pixel_match, frame_done;
    logic [29:0] sum_x, sum_y;
    logic [19:0] pix_count;

    // Divider: dq holds the dividend shifting out and the quotient shifting in.
    logic [29:0] dq, div_y_src;
    logic [19:0] divisor, rem;
    logic [4:0]  step;
    logic [10:0] quot_x;
    logic        found;

    logic [20:0] trial;
    logic        trial_ge, last_step;
    logic [19:0] rem_next;
    logic [29:0] dq_next;

    // Pixel classification, frame-end detection and one restoring-division step.
    always_comb begin
        pixel_match = pixel_valid_in && (hcount_in < H_LIM) && (vcount_in < V_LIM)
                      && (pixel_in[11:8] >= R_MIN) && (pixel_in[7:4] <= GB_MAX)
                      && (pixel_in[3:0] <= GB_MAX);
        frame_done  = (hcount_in == H_LIM) && (vcount_in == V_LIM);
        trial       = {rem, dq[29]};
        trial_ge    = (trial >= {1'b0, divisor});
        rem_next    = trial_ge ? 20'(trial - {1'b0, divisor}) : trial[19:0];
        dq_next     = {dq[28:0], trial_ge};
        last_step   = (step == 5'd29);
        busy_out    = (state != IDLE);
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; a too-small frame skips straight to UPDATE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_done) next_state = (pix_count < MIN_CNT) ? UPDATE : DIV_X;
            DIV_X:   if (last_step) next_state = DIV_Y;
            DIV_Y:   if (last_step) next_state = UPDATE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-frame accumulators; frame end always clears them, even while busy.
    always_ff @(posedge clk_in) begin
        if (rst_in || frame_done) begin
            sum_x     <= '0;
            sum_y     <= '0;
            pix_count <= '0;
        end else if (pixel_match) begin
            sum_x     <= sum_x + 30'(hcount_in);
            sum_y     <= sum_y + 30'(vcount_in);
            pix_count <= pix_count + 20'd1;
        end
    end

    // Latch the frame totals and run the shared divider for x then y.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dq        <= '0;
            div_y_src <= '0;
            divisor   <= '0;
            rem       <= '0;
            step      <= '0;
            quot_x    <= '0;
            found     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_done) begin
                        dq        <= sum_x;
                        div_y_src <= sum_y;
                        divisor   <= pix_count;
                        rem       <= '0;
                        step      <= '0;
                        found     <= (pix_count >= MIN_CNT);
                    end
                end
                DIV_X: begin
                    if (last_step) begin
                        quot_x <= dq_next[10:0];
                        dq     <= div_y_src;
                        rem    <= '0;
                        step   <= '0;
                    end else begin
                        dq     <= dq_next;
                        rem    <= rem_next;
                        step   <= step + 5'd1;
                    end
                end
                DIV_Y: begin
                    dq   <= dq_next;
                    rem  <= rem_next;
                    step <= last_step ? 5'd0 : step + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs change only on the UPDATE edge or on reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            katana_x    <= X_HOME;
            katana_y    <= Y_HOME;
            found_out   <= 1'b0;
            new_pos_out <= 1'b0;
        end else begin
            new_pos_out <= (state == UPDATE);
            if (state == UPDATE) begin
                found_out <= found;
                if (found) begin
                    katana_x <= quot_x;
                    katana_y <= dq[9:0];
                end
            end
        end
    end

endmodule

// File: doc/katana_tracker.md
Name: katana_tracker

Overview:
Produces the katana_x / katana_y position that the game logic consumes. It watches the camera pixel stream and finds the centroid of pixels that match a red marker colour over one full frame. At every frame end it divides the accumulated coordinate sums by the pixel count using a sequential divider. It then presents the new position, held stable for the whole of the next frame.

Parameters:
H_ACTIVE, 1024, active pixels per line; frame end is the cycle with hcount_in==H_ACTIVE and vcount_in==V_ACTIVE.
V_ACTIVE, 768, active lines per frame.
R_MIN, 4'd10, minimum red nibble for a marker pixel.
GB_MAX, 4'd5, maximum green and blue nibble for a marker pixel.
MIN_PIXELS, 64, minimum matched-pixel count for a valid detection.

Ports:
clk_in  input  1  system clock, single domain.
rst_in  input  1  synchronous, active-high reset.
hcount_in  input  11  current pixel column.
vcount_in  input  10  current pixel row.
pixel_valid_in  input  1  pixel_in is valid this cycle.
pixel_in  input  12  camera pixel, RGB444 as {R[11:8],G[7:4],B[3:0]}.
katana_x  output  11  centroid column, registered.
katana_y  output  10  centroid row, registered.
found_out  output  1  last completed frame met MIN_PIXELS.
new_pos_out  output  1  one-cycle pulse when the outputs are updated.
busy_out  output  1  high while the divider is running.

Behaviour:
- Match rule: pixel_valid_in && hcount_in<H_ACTIVE && vcount_in<V_ACTIVE && R>=R_MIN && G<=GB_MAX && B<=GB_MAX.
- On each match: sum_x += hcount_in (30 bits), sum_y += vcount_in (30 bits), count += 1 (20 bits). Accumulators cannot overflow at the default sizes.
- frame_done = (hcount_in==H_ACTIVE && vcount_in==V_ACTIVE). It lies outside the active area, so it never accumulates.
- FSM states: IDLE, DIV_X, DIV_Y, UPDATE.
- IDLE, on the frame_done edge T:
  - latch sum_x, sum_y and count into divider registers;
  - clear all accumulators in the same edge;
  - if latched count < MIN_PIXELS, go to UPDATE with found=0; otherwise go to DIV_X.
- DIV_X: restoring division, one quotient bit per cycle, 30 cycles.
- DIV_Y: same divider, 30 cycles.
- UPDATE, 1 cycle. On its ending edge:
  - if found=1: katana_x <= quotient_x[10:0], katana_y <= quotient_y[9:0], found_out <= 1;
  - if found=0: katana_x / katana_y keep their previous values, found_out <= 0;
  - new_pos_out <= 1 for exactly one cycle, then return to IDLE.
- Latency, valid detection: DIV_X spans T+1..T+30, DIV_Y spans T+31..T+60, UPDATE is T+61. New outputs and the new_pos_out pulse are visible in cycle T+62.
- Latency, below-threshold frame: UPDATE is T+1, pulse visible in T+2.
- Quotient is floor(sum/count). The centroid is always <H_ACTIVE and <V_ACTIVE, so no clamp is needed.
- busy_out = (state != IDLE).
- Accumulation continues normally while busy; the next frame's pixels are counted.
- frame_done while busy: accumulators are cleared, no new division starts, and the frame is dropped. Unreachable at real frame rates, but required.
- Reset, mid-operation or not:
  - katana_x=H_ACTIVE/2 (512), katana_y=V_ACTIVE/2 (384);
  - found_out=0, new_pos_out=0, busy_out=0;
  - state IDLE, all accumulators and divider registers 0.
- Outputs only change on the UPDATE edge or on reset.

Test Plan:
- 10x10 red block (pixel 12'hF00) at x=100..109, y=200..209, frame_done at T -> katana_x=104, katana_y=204, found_out=1, new_pos_out high only in cycle T+62.
- Single red pixel at (5,5) with MIN_PIXELS=64 -> new_pos_out pulses at T+2, found_out=0, position holds 512/384.
- Full-frame red, 786432 matches -> katana_x=511, katana_y=383, no overflow.
- Rejection cases: pixel 12'hF60 (green too high) and pixel_valid_in=0 cycles -> not counted. Pixels at hcount_in>=1024 -> ignored.
- Second frame_done injected at T+10 while busy -> first result still lands at T+62, second frame dropped, accumulators zero afterwards.
- rst_in asserted at T+20 mid-division -> all outputs reset values next cycle, busy_out=0, next valid frame computes correctly.
